// File: rtl/rv_bridge_pkg.sv
// Shared types and constants for the picorv32-to-OBI memory bridge.
package rv_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } bridge_state_t;

    typedef enum logic {
        PORT_INSTR,
        PORT_DATA
    } port_sel_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rv_mem_bus_bridge_if.sv
// OBI-style instruction and data ports of the bridge; master = bridge side, slave = interconnect.
interface rv_mem_bus_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              instr_req_o;
    logic              instr_gnt_i;
    logic              instr_rvalid_i;
    logic [ADDR_W-1:0] instr_addr_o;
    logic [DATA_W-1:0] instr_rdata_i;
    logic              instr_err_i;

    logic              data_req_o;
    logic              data_gnt_i;
    logic              data_rvalid_i;
    logic              data_we_o;
    logic [BE_W-1:0]   data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [DATA_W-1:0] data_wdata_o;
    logic [DATA_W-1:0] data_rdata_i;
    logic              data_err_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

endinterface

// File: rtl/rv_bridge_watchdog.sv
// Request watchdog: counts busy cycles since clear; expired is high during the
// TIMEOUT_CYCLES-th enabled cycle. TIMEOUT_CYCLES = 0 ties it off.
module rv_bridge_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = clk ^ rst ^ clear ^ en;
        assign expired       = 1'b0;
    end else begin : g_on
        localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

        logic [CntW-1:0] count_q;

        // Saturates at Last so expired stays asserted until the FSM reacts.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                count_q <= '0;
            end else if (en && (count_q != Last)) begin
                count_q <= count_q + CntW'(1);
            end
        end

        assign expired = en && (count_q == Last);
    end

endmodule

// File: rtl/rv_mem_bus_bridge.sv
// picorv32 native memory interface to OBI instruction/data ports, one transaction in flight.
// bus_err_o and timeout_o pulse in the DONE cycle, alongside mem_ready.
module rv_mem_bus_bridge
    import rv_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
    localparam int unsigned BE_W          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [BE_W-1:0]   mem_wstrb,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,

    rv_mem_bus_bridge_if.master bus,

    output logic              bus_err_o,
    output logic              timeout_o,
    output logic [ADDR_W-1:0] fault_addr_o
);

    localparam logic [DATA_W-1:0] ErrData = DATA_W'(ERR_RDATA);

    bridge_state_t     state_q, state_d;
    port_sel_t         sel_q, sel_new;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        drain_q, drain_d;
    logic              bus_err_q, timeout_q;
    logic [ADDR_W-1:0] fault_addr_q;

    logic              load, resp_cap, abort;
    logic              wd_clear, wd_en, wd_expired;
    logic              gnt_sel, rvalid_sel, err_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic              instr_req, data_req;

    assign sel_new = (mem_instr && (mem_wstrb == '0)) ? PORT_INSTR : PORT_DATA;

    assign gnt_sel    = (sel_q == PORT_INSTR) ? bus.instr_gnt_i    : bus.data_gnt_i;
    assign rvalid_sel = (sel_q == PORT_INSTR) ? bus.instr_rvalid_i : bus.data_rvalid_i;
    assign err_sel    = (sel_q == PORT_INSTR) ? bus.instr_err_i    : bus.data_err_i;
    assign rdata_sel  = (sel_q == PORT_INSTR) ? bus.instr_rdata_i  : bus.data_rdata_i;

    assign wd_en = (state_q == REQ) || (state_q == RESP);

    rv_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .en     (wd_en),
        .expired(wd_expired)
    );

    // Handshake events take priority over a watchdog expiring in the same cycle.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        wd_clear = 1'b0;
        resp_cap = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid && !drain_q[sel_new]) begin
                    state_d  = REQ;
                    load     = 1'b1;
                    wd_clear = 1'b1;
                end
            end
            REQ: begin
                if (gnt_sel) begin
                    state_d = RESP;
                end else if (wd_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            RESP: begin
                if (rvalid_sel) begin
                    state_d  = DONE;
                    resp_cap = 1'b1;
                end else if (wd_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A response still owed by the interconnect after an abort must be swallowed.
    always_comb begin
        drain_d = drain_q;
        if (drain_q[PORT_INSTR] && bus.instr_rvalid_i) begin
            drain_d[PORT_INSTR] = 1'b0;
        end
        if (drain_q[PORT_DATA] && bus.data_rvalid_i) begin
            drain_d[PORT_DATA] = 1'b0;
        end
        if (abort && (state_q == RESP)) begin
            drain_d[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= PORT_INSTR;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            drain_q      <= '0;
            bus_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            bus_err_q <= 1'b0;
            timeout_q <= 1'b0;
            if (load) begin
                sel_q   <= sel_new;
                addr_q  <= mem_addr;
                we_q    <= |mem_wstrb;
                be_q    <= (|mem_wstrb) ? mem_wstrb : '1;
                wdata_q <= (|mem_wstrb) ? mem_wdata : '0;
            end
            if (resp_cap) begin
                rdata_q <= we_q ? '0 : (err_sel ? ErrData : rdata_sel);
                if (err_sel) begin
                    bus_err_q    <= 1'b1;
                    fault_addr_q <= addr_q;
                end
            end
            if (abort) begin
                rdata_q      <= we_q ? '0 : ErrData;
                timeout_q    <= 1'b1;
                fault_addr_q <= addr_q;
            end
        end
    end

    assign instr_req = (state_q == REQ) && (sel_q == PORT_INSTR);
    assign data_req  = (state_q == REQ) && (sel_q == PORT_DATA);

    assign bus.instr_req_o  = instr_req;
    assign bus.instr_addr_o = instr_req ? addr_q : '0;

    assign bus.data_req_o   = data_req;
    assign bus.data_we_o    = data_req && we_q;
    assign bus.data_be_o    = data_req ? be_q : '0;
    assign bus.data_addr_o  = data_req ? addr_q : '0;
    assign bus.data_wdata_o = data_req ? wdata_q : '0;

    assign mem_ready    = (state_q == DONE);
    assign mem_rdata    = mem_ready ? rdata_q : '0;
    assign bus_err_o    = bus_err_q;
    assign timeout_o    = timeout_q;
    assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_rv_mem_bus_bridge.sv
// Bench for rv_mem_bus_bridge: vector table plus hand sequences for drain and reset.
module tb_rv_mem_bus_bridge;

    localparam int unsigned TO    = 8;
    localparam int          NEVER = 1000;
    localparam int          NV    = 10;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gd;
        int          rd;
        logic [31:0] resp_rdata;
        logic        resp_err;
        logic        exp_data;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        bus_err;
        logic        timeout;
        logic [31:0] fault;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic        timeout;
    logic [31:0] fault_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_id   = 0;
    logic [31:0] fault_model = '0;
    exp_t        sb[$];
    vec_t        vecs[NV];

    rv_mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    rv_mem_bus_bridge #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .bus         (bus_if),
        .bus_err_o   (bus_err),
        .timeout_o   (timeout),
        .fault_addr_o(fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%0d] %s: got %0h, expected %0h", cur_id, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int gd, input int rd,
                                input logic [31:0] rsp, input logic rerr, input logic exp_data,
                                input logic exp_we, input logic [3:0] exp_be,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic exp_to);
        vec_t v;
        v.instr = instr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.gd = gd; v.rd = rd; v.resp_rdata = rsp; v.resp_err = rerr;
        v.exp_data = exp_data; v.exp_we = exp_we; v.exp_be = exp_be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_to = exp_to;
        return v;
    endfunction

    task automatic clear_resp();
        bus_if.instr_gnt_i    = 1'b0;
        bus_if.instr_rvalid_i = 1'b0;
        bus_if.instr_rdata_i  = '0;
        bus_if.instr_err_i    = 1'b0;
        bus_if.data_gnt_i     = 1'b0;
        bus_if.data_rvalid_i  = 1'b0;
        bus_if.data_rdata_i   = '0;
        bus_if.data_err_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_txn(input vec_t v);
        exp_t e;
        mem_valid = 1'b1;
        mem_instr = v.instr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        if (v.exp_err || v.exp_to) fault_model = v.addr;
        e.rdata   = v.exp_rdata;
        e.bus_err = v.exp_err;
        e.timeout = v.exp_to;
        e.fault   = fault_model;
        sb.push_back(e);
    endtask

    // Acts as the interconnect for one transaction and checks the completion.
    task automatic finish_txn(input vec_t v, input int extra);
        int   cyc = 0;
        int   req_cycles = 0;
        int   resp_cycles = 0;
        int   exp_lat;
        int   exp_req;
        bit   granted = 0;
        bit   done = 0;
        logic req_sel, req_oth;
        exp_t e;
        exp_lat = v.exp_to ? int'(TO) + 1 + extra : 3 + v.gd + v.rd + extra;
        exp_req = (v.gd >= NEVER) ? int'(TO) : v.gd + 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            clear_resp();
            req_sel = v.exp_data ? bus_if.data_req_o : bus_if.instr_req_o;
            req_oth = v.exp_data ? bus_if.instr_req_o : bus_if.data_req_o;
            if (mem_ready) begin
                done = 1;
                mem_valid = 1'b0;
                if (sb.size() == 0) begin
                    check("scoreboard empty at mem_ready", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("mem_rdata", mem_rdata, e.rdata);
                    check("bus_err_o", bus_err, e.bus_err);
                    check("timeout_o", timeout, e.timeout);
                    check("fault_addr_o", fault_addr, e.fault);
                end
                check("latency", cyc, exp_lat);
                check("req cycles", req_cycles, exp_req);
            end else begin
                check("mem_rdata while not ready", mem_rdata, 0);
                check("pulses while not ready", {bus_err, timeout}, 0);
                check("other port req", req_oth, 0);
                if (v.exp_data) check("idle instr addr", bus_if.instr_addr_o, 0);
                else check("idle data fields",
                           {bus_if.data_we_o, bus_if.data_be_o, bus_if.data_addr_o}, 0);
                if (req_sel) begin
                    req_cycles++;
                    if (v.exp_data) begin
                        check("data_addr_o", bus_if.data_addr_o, v.addr);
                        check("data_we/be", {bus_if.data_we_o, bus_if.data_be_o},
                              {v.exp_we, v.exp_be});
                        if (v.exp_we) check("data_wdata_o", bus_if.data_wdata_o, v.wdata);
                    end else begin
                        check("instr_addr_o", bus_if.instr_addr_o, v.addr);
                    end
                    if (!granted && v.gd < NEVER && req_cycles > v.gd) begin
                        granted = 1;
                        if (v.exp_data) bus_if.data_gnt_i = 1'b1;
                        else bus_if.instr_gnt_i = 1'b1;
                    end
                end else if (granted) begin
                    resp_cycles++;
                    if (v.rd < NEVER && resp_cycles > v.rd) begin
                        if (v.exp_data) begin
                            bus_if.data_rvalid_i = 1'b1;
                            bus_if.data_rdata_i  = v.resp_rdata;
                            bus_if.data_err_i    = v.resp_err;
                        end else begin
                            bus_if.instr_rvalid_i = 1'b1;
                            bus_if.instr_rdata_i  = v.resp_rdata;
                            bus_if.instr_err_i    = v.resp_err;
                        end
                    end else if (v.exp_data) begin
                        // Stray erroring response on the unselected port must be ignored.
                        bus_if.instr_rvalid_i = 1'b1;
                        bus_if.instr_rdata_i  = 32'hFFFF_FFFF;
                        bus_if.instr_err_i    = 1'b1;
                    end else begin
                        bus_if.data_rvalid_i = 1'b1;
                        bus_if.data_rdata_i  = 32'hFFFF_FFFF;
                        bus_if.data_err_i    = 1'b1;
                    end
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL [%0d] mem_ready wait: got no pulse in %0d cycles, expected one", cur_id,
                     cyc);
            mem_valid = 1'b0;
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        vec_t vt, vs, vf;
        vecs[0] = mk(1, 32'h80, 0, 4'h0, 0, 0, 32'h13, 0, 0, 0, 4'h0, 32'h13, 0, 0);
        vecs[1] = mk(0, 32'h1000_0004, 32'hA5A5_1234, 4'b0011, 4, 0, 32'h5555_5555, 0,
                     1, 1, 4'b0011, 32'h0, 0, 0);
        vecs[2] = mk(0, 32'h2000_0000, 0, 4'h0, 0, 0, 32'h1234_0000, 1, 1, 0, 4'hF,
                     32'hDEAD_BEEF, 1, 0);
        vecs[3] = mk(0, 32'h3000_0010, 0, 4'h0, 1, 2, 32'hCAFE_F00D, 0, 1, 0, 4'hF,
                     32'hCAFE_F00D, 0, 0);
        vecs[4] = mk(1, 32'h44, 32'h1234_5678, 4'hF, 0, 1, 32'h0BAD_0BAD, 0, 1, 1, 4'hF,
                     32'h0, 0, 0);
        vecs[5] = mk(1, 32'h84, 0, 4'h0, 2, 3, 32'h93, 0, 0, 0, 4'h0, 32'h93, 0, 0);
        vecs[6] = mk(1, 32'h88, 0, 4'h0, 0, 0, 32'h0, 1, 0, 0, 4'h0, 32'hDEAD_BEEF, 1, 0);
        vecs[7] = mk(0, 32'h50, 32'hFF00_0000, 4'b1000, 1, 0, 32'h0, 1, 1, 1, 4'b1000,
                     32'h0, 1, 0);
        vecs[8] = mk(0, 32'h60, 0, 4'h0, 3, 3, 32'h7777_0001, 0, 1, 0, 4'hF,
                     32'h7777_0001, 0, 0);
        vecs[9] = mk(1, 32'h90, 0, 4'h0, NEVER, NEVER, 32'h0, 0, 0, 0, 4'h0,
                     32'hDEAD_BEEF, 0, 1);
        vt = mk(0, 32'h2000_0100, 0, 4'h0, 0, NEVER, 32'h0, 0, 1, 0, 4'hF, 32'hDEAD_BEEF, 0, 1);
        vs = mk(0, 32'h2000_0200, 0, 4'h0, 0, 0, 32'h1111_2222, 0, 1, 0, 4'hF,
                32'h1111_2222, 0, 0);
        vf = mk(1, 32'h200, 0, 4'h0, 0, 1, 32'h0010_0073, 0, 0, 0, 4'h0, 32'h0010_0073, 0, 0);

        rst = 1'b1;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        clear_resp();
        repeat (3) @(negedge clk);
        check("reset mem_ready/rdata", {mem_ready, mem_rdata}, 0);
        check("reset reqs", {bus_if.instr_req_o, bus_if.data_req_o}, 0);
        check("reset pulses/fault", {bus_err, timeout, fault_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            cur_id = i;
            start_txn(vecs[i]);
            finish_txn(vecs[i], (i == 0) ? 0 : 1);
        end

        // Abort in RESP on the data port, then a data read must wait for the late response.
        cur_id = 10;
        start_txn(vt);
        finish_txn(vt, 1);
        cur_id = 11;
        start_txn(vs);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall while draining", {bus_if.data_req_o, bus_if.instr_req_o, mem_ready}, 0);
        end
        bus_if.data_rvalid_i = 1'b1;
        bus_if.data_rdata_i  = 32'hBAD0_BAD0;
        bus_if.data_err_i    = 1'b1;
        finish_txn(vs, 1);

        // Synchronous reset while waiting for rvalid.
        cur_id = 12;
        idle(2);
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h100; mem_wstrb = '0;
        @(negedge clk);
        check("fetch req before reset", bus_if.instr_req_o, 1);
        bus_if.instr_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.instr_gnt_i = 1'b0;
        rst = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fault_model = '0;
        check("post-reset mem_ready/rdata", {mem_ready, mem_rdata}, 0);
        check("post-reset instr", {bus_if.instr_req_o, bus_if.instr_addr_o}, 0);
        check("post-reset data", {bus_if.data_req_o, bus_if.data_we_o, bus_if.data_be_o,
                                  bus_if.data_addr_o}, 0);
        check("post-reset pulses/fault", {bus_err, timeout, fault_addr}, 0);
        @(negedge clk);
        check("no mem_ready after reset", {mem_ready, bus_if.instr_req_o}, 0);

        cur_id = 13;
        start_txn(vf);
        finish_txn(vf, 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mem_bus_bridge.md
Name: rv_mem_bus_bridge

Overview:
- Parametrised bridge from the picorv32 native memory interface (valid/ready, single outstanding) to two OBI-style request/grant/rvalid master ports: instruction and data.
- Sits between picorv32 and the processor-block interconnect.
- Full handshake FSM: holds request until grant, waits for rvalid, returns registered read data.
- Routes data reads as well as writes.
- Reports bus errors and watchdog timeouts.

Parameters:
- ADDR_W, 32, address width of core and both ports.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, max cycles from request issue to rvalid before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, value returned on mem_rdata for errored or timed-out reads (low DATA_W bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  core request valid
- mem_instr  in  1  core request is instruction fetch
- mem_addr  in  ADDR_W  core address
- mem_wdata  in  DATA_W  core write data
- mem_wstrb  in  BE_W  core write strobes; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  read data, valid while mem_ready=1
- instr_req_o  out  1  instruction request
- instr_gnt_i  in  1  instruction grant
- instr_rvalid_i  in  1  instruction response valid
- instr_addr_o  out  ADDR_W  instruction address
- instr_rdata_i  in  DATA_W  instruction read data
- instr_err_i  in  1  instruction response error (qualified by rvalid)
- data_req_o  out  1  data request
- data_gnt_i  in  1  data grant
- data_rvalid_i  in  1  data response valid
- data_we_o  out  1  data write enable
- data_be_o  out  BE_W  data byte enables
- data_addr_o  out  ADDR_W  data address
- data_wdata_o  out  DATA_W  data write data
- data_rdata_i  in  DATA_W  data read data
- data_err_i  in  1  data response error
- bus_err_o  out  1  one-cycle pulse on errored response
- timeout_o  out  1  one-cycle pulse on watchdog abort
- fault_addr_o  out  ADDR_W  address of the last errored or timed-out transaction

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, watchdog cleared, drain flags cleared.
- Reset mid-transaction: abort immediately, no mem_ready pulse.
- Routing: mem_instr=1 and mem_wstrb=0 goes to the instruction port. Everything else goes to the data port: we = |mem_wstrb, be = wstrb for writes, all-ones for reads.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Enters REQ when mem_valid=1 and the target port's drain flag is clear.
  - Latches addr, wdata, be, we and port select into registers.
- REQ:
  - Drives the selected *_req_o = 1 with the latched fields, which stay stable until grant.
  - On gnt: req drops next cycle, go to RESP.
- RESP:
  - Samples the selected *_rvalid_i only in this state.
  - On rvalid: capture rdata (or ERR_RDATA if err), go to DONE.
  - On err: pulse bus_err_o and load fault_addr_o.
- DONE:
  - mem_ready = 1 for exactly one cycle with the registered mem_rdata, then IDLE.
  - No new request is accepted in DONE.
  - Minimum latency: valid to ready is 3 cycles with gnt in the first REQ cycle and rvalid in the first RESP cycle.
- Write responses: mem_rdata = 0.
- Watchdog:
  - Counter cleared on IDLE→REQ; increments in REQ and RESP.
  - At TIMEOUT_CYCLES: pulse timeout_o, load fault_addr_o, drop req, go to DONE with mem_rdata = ERR_RDATA.
  - If the abort happens in RESP, set that port's drain flag. The next rvalid on that port is discarded and clears the flag.
  - A new request to a draining port waits in IDLE.
- Simultaneous events:
  - Timeout expiring in the same cycle as gnt or rvalid: the handshake wins, no timeout.
  - rvalid on the non-selected port: ignored unless it clears a drain flag.
- Idle outputs: the inactive port drives req=0 and zeros on addr/wdata/be/we. mem_rdata = 0 when mem_ready = 0.

Decomposition:
- Package rv_bridge_pkg:
  - bridge_state_t enum (IDLE, REQ, RESP, DONE)
  - port_sel_t enum (PORT_INSTR, PORT_DATA)
  - default ERR_RDATA constant
- Sub-module rv_bridge_watchdog:
  - parametrised counter with clear, enable and expired outputs.
  - Tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Fetch at 0x80, gnt same cycle as req, rvalid rdata 0x00000013 one cycle later → mem_ready pulse at cycle 3, mem_rdata=0x00000013, data_req_o never asserted.
- Data write addr 0x1000_0004, wstrb 4'b0011, wdata 0xA5A5_1234, gnt held off 4 cycles → data_req_o held 5 cycles with stable fields, data_we_o=1, data_be_o=0011, mem_rdata=0.
- Data read 0x2000_0000 with rvalid+err → mem_rdata=0xDEADBEEF, bus_err_o one-cycle pulse, fault_addr_o=0x2000_0000.
- TIMEOUT_CYCLES=8, granted but no rvalid → timeout_o at 8th cycle, mem_ready with 0xDEADBEEF. Next data read stalls in IDLE until the late rvalid arrives and is discarded, then proceeds.
- rst asserted in RESP → next cycle all outputs 0, no mem_ready. A later fetch completes normally.
- Back-to-back: new mem_valid the cycle after DONE → no gap beyond one IDLE cycle, no duplicate request issued.
